// File: rtl/router_pkg.sv
// Shared router types and constants: arbiter FSM states, flit geometry and field positions.
package router_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } arb_state_t;

  localparam int ARB_N_PORTS     = 4;
  localparam int FLIT_W          = 32;
  localparam int FLIT_DEST_MSB   = 31;
  localparam int FLIT_DEST_LSB   = 30;
  localparam int FLIT_DELTA_MSB  = 29;
  localparam int FLIT_DELTA_LSB  = 28;
  localparam int FLIT_PAYLOAD_MSB = 27;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic [1:0] flit_dest(input flit_t f);
    return f[FLIT_DEST_MSB:FLIT_DEST_LSB];
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Flop-chain synchronizer for 2-phase toggle signals; async active-low reset clears every stage.
module toggle_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter sharing one 2-phase req/ack output channel among N_PORTS inputs.
// Define ARB_CDC_SYNC_EN to synchronize in_req and out_ack for asynchronous neighbours.
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int N_PORTS     = ARB_N_PORTS,
  parameter int DATA_W      = FLIT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          in_req,
  output logic [N_PORTS-1:0]          in_ack,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  output logic                        out_req,
  input  logic                        out_ack,
  output logic [DATA_W-1:0]           out_data,
  output logic                        grant_valid,
  output logic [$clog2(N_PORTS)-1:0]  grant_idx
);

  localparam int IDX_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0] req_s;
  logic               ack_s;

`ifdef ARB_CDC_SYNC_EN
  toggle_sync #(.WIDTH(N_PORTS), .STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_req),
    .q   (req_s)
  );

  toggle_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (out_ack),
    .q   (ack_s)
  );
`else
  assign req_s = in_req;
  assign ack_s = out_ack;
`endif

  // Returns {found, index}; lowest offset from ptr wins, so scan from the far end down.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_PORTS-1:0] pend,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORTS) idx -= N_PORTS;
      if (pend[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  arb_state_t         state, state_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [N_PORTS-1:0] in_ack_nx;
  logic               out_req_nx;
  logic [DATA_W-1:0]  out_data_nx;
  logic               grant_valid_nx;
  logic [IDX_W-1:0]   grant_idx_nx;

  logic [N_PORTS-1:0] pending;
  logic [IDX_W:0]     pick;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  assign pending   = req_s ^ in_ack;
  assign pick      = rr_pick(pending, rr_ptr);
  assign win_found = pick[IDX_W];
  assign win_idx   = pick[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      in_ack      <= '0;
      out_req     <= 1'b0;
      out_data    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_ptr_nx;
      in_ack      <= in_ack_nx;
      out_req     <= out_req_nx;
      out_data    <= out_data_nx;
      grant_valid <= grant_valid_nx;
      grant_idx   <= grant_idx_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    rr_ptr_nx      = rr_ptr;
    in_ack_nx      = in_ack;
    out_req_nx     = out_req;
    out_data_nx    = out_data;
    grant_valid_nx = grant_valid;
    grant_idx_nx   = grant_idx;
    case (state)
      IDLE: begin
        if (win_found) begin
          out_data_nx    = in_data[int'(win_idx)*DATA_W +: DATA_W];
          out_req_nx     = ~out_req;
          grant_idx_nx   = win_idx;
          grant_valid_nx = 1'b1;
          state_nx       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Downstream has acked once its toggle catches up with ours.
        if (ack_s == out_req) begin
          in_ack_nx[grant_idx] = ~in_ack[grant_idx];
          rr_ptr_nx            = (grant_idx == IDX_W'(N_PORTS - 1)) ? '0
                                                                     : grant_idx + IDX_W'(1);
          grant_valid_nx       = 1'b0;
          state_nx             = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Randomized and directed bench for output_port_arbiter against a round-robin reference model.
module tb_output_port_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int SYN = 2;
`ifdef ARB_CDC_SYNC_EN
  localparam int REQ_LAT = 1 + SYN;
  localparam int ACK_LAT = 1 + SYN;
`else
  localparam int REQ_LAT = 1;
  localparam int ACK_LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_req;
  logic [N-1:0]   in_ack;
  logic [N*W-1:0] in_data;
  logic           out_req;
  logic           out_ack;
  logic [W-1:0]   out_data;
  logic           grant_valid;
  logic [1:0]     grant_idx;

  output_port_arbiter #(.N_PORTS(N), .DATA_W(W), .SYNC_STAGES(SYN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_req      (in_req),
    .in_ack      (in_ack),
    .in_data     (in_data),
    .out_req     (out_req),
    .out_ack     (out_ack),
    .out_data    (out_data),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected ack toggles, round-robin pointer, expected out_req level.
  logic [N-1:0] model_ack;
  int           model_ptr;
  logic         exp_out_req;
  logic [W-1:0] flit [N];
  logic [W-1:0] exp_q [$];

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (in_req[i] !== model_ack[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    model_ack   = '0;
    model_ptr   = 0;
    exp_out_req = 1'b0;
  endtask

  task automatic raise_req(input int i, input logic [W-1:0] d);
    flit[i]            = d;
    in_data[i*W +: W]  = d;
    in_req[i]          = ~in_req[i];
  endtask

  // Waits for the next grant, checks it against the model, holds for `hold` cycles, then acks.
  task automatic serve(input int hold, input int req_lat, input string name, output int got);
    int           exp_w;
    logic [W-1:0] exp_d;
    logic [N-1:0] ack_before;
    int           waited;
    got   = -1;
    exp_w = model_pick();
    exp_d = (exp_w >= 0) ? flit[exp_w] : '0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (out_req === exp_out_req && waited < 64);
    checks++;
    if (out_req === exp_out_req || exp_w < 0) begin
      errors++;
      $display("FAIL %s grant: out_req=%b stayed at %b after %0d cycles, model winner %0d",
               name, out_req, exp_out_req, waited, exp_w);
      return;
    end
    exp_out_req = ~exp_out_req;
    got = int'(grant_idx);
    if (req_lat >= 0) begin
      checks++;
      if (waited !== req_lat) begin
        errors++;
        $display("FAIL %s req_latency: got %0d cycles, want %0d", name, waited, req_lat);
      end
    end
    checks++;
    if (grant_idx !== 2'(exp_w) || out_data !== exp_d || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s grant: idx=%0d data=%h gv=%b, want idx=%0d data=%h gv=1",
               name, grant_idx, out_data, grant_valid, exp_w, exp_d);
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (out_data !== exp_d || out_req !== exp_out_req || in_ack !== model_ack ||
          grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s hold cyc%0d: data=%h req=%b ack=%b gv=%b, want data=%h req=%b ack=%b gv=1",
                 name, c, out_data, out_req, in_ack, grant_valid, exp_d, exp_out_req, model_ack);
      end
    end
    ack_before = model_ack;
    out_ack = exp_out_req;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (in_ack === ack_before && waited < 64);
    model_ack[exp_w] = ~model_ack[exp_w];
    model_ptr        = (exp_w + 1) % N;
    checks++;
    if (in_ack !== model_ack || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s complete: in_ack=%b gv=%b, want in_ack=%b gv=0",
               name, in_ack, grant_valid, model_ack);
    end
    if (req_lat >= 0) begin
      checks++;
      if (waited !== ACK_LAT) begin
        errors++;
        $display("FAIL %s ack_latency: got %0d cycles, want %0d", name, waited, ACK_LAT);
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
    for (int i = 0; i < N; i++) flit[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (in_ack !== '0 || out_req !== 1'b0 || out_data !== '0 || grant_valid !== 1'b0 ||
        grant_idx !== '0) begin
      errors++;
      $display("FAIL reset_state: ack=%b req=%b data=%h gv=%b idx=%0d, want all zero",
               in_ack, out_req, out_data, grant_valid, grant_idx);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_req !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: req=%b gv=%b, want 0 0", out_req, grant_valid);
    end
  endtask

  task automatic test_single();
    int got;
    raise_req(0, 32'h4FFFFFFF);
    serve(3, REQ_LAT, "single", got);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL single_winner: got %0d, want 0", got);
    end
  endtask

  task automatic test_contention();
    int got;
    raise_req(1, 32'h0EEEEEEE);
    raise_req(2, 32'h0DDDDDDD);
    raise_req(3, 32'h0CCCCCCC);
    exp_q = {32'd1, 32'd2, 32'd3};
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      serve(0, -1, "contention", got);
      checks++;
      if (got !== int'(e)) begin
        errors++;
        $display("FAIL contention_order: got %0d, want %0d", got, e);
      end
    end
  endtask

  task automatic test_fairness();
    int got;
    raise_req(0, $urandom);
    raise_req(2, $urandom);
    exp_q = {32'd0, 32'd2, 32'd0, 32'd2};
    for (int r = 0; r < 4; r++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      serve(0, -1, "fairness", got);
      checks++;
      if (got !== int'(e)) begin
        errors++;
        $display("FAIL fairness_round%0d: got %0d, want %0d", r, got, e);
      end
      if (r < 3 && got >= 0) raise_req(got, $urandom);
    end
    while (model_pick() >= 0) serve(0, -1, "fairness_drain", got);
  endtask

  task automatic test_backpressure();
    int got;
    raise_req(1, 32'h9A5A5A5A);
    serve(20, REQ_LAT, "backpressure", got);
  endtask

  task automatic test_reset_mid();
    int got;
    int waited;
    raise_req(2, 32'h12345678);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (grant_valid !== 1'b1 && waited < 64);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ack !== '0 || out_req !== 1'b0 || out_data !== '0 || grant_valid !== 1'b0 ||
        grant_idx !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: ack=%b req=%b data=%h gv=%b idx=%0d, want all zero",
               in_ack, out_req, out_data, grant_valid, grant_idx);
    end
    in_req  = '0;
    out_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    raise_req(3, 32'h8BADF00D);
    serve(2, REQ_LAT, "after_reset", got);
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL after_reset_winner: got %0d, want 3", got);
    end
  endtask

  task automatic test_wrap();
    int got;
    raise_req(0, 32'h00000A0A);
    raise_req(3, 32'h30003030);
    serve(1, -1, "wrap", got);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL wrap_winner: got %0d, want 0", got);
    end
    serve(0, -1, "wrap_next", got);
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL wrap_next_winner: got %0d, want 3", got);
    end
  endtask

  task automatic test_random();
    int got;
    for (int r = 0; r < 25; r++) begin
      int mask;
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++) if (mask[i]) raise_req(i, $urandom);
      while (model_pick() >= 0) serve($urandom_range(0, 4), -1, "random", got);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
